mc_key_extract: RTL and testbench

//  Front end of the memcache hash path. Parses an ASCII memcache "get" command from a byte stream
//  and extracts each key, packing it into three little-endian 32-bit words plus a byte length.

---
 rtl/mc_pkg.sv | 40 ++++
 rtl/mc_key_pack.sv | 47 ++++
 rtl/mc_key_extract.sv | 168 ++++++++++++++++
 tb/tb_mc_key_extract.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the memcache key extraction path: ASCII codes, the
// "get " command literal, error encodings and the parser state encoding.
package mc_pkg;

   localparam int MAX_KEY_DEF = 12;

   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0d;
   localparam logic [7:0] CH_LF    = 8'h0a;
   localparam logic [7:0] CH_PR_LO = 8'h21;
   localparam logic [7:0] CH_PR_HI = 8'h7e;

   // "get " with 'g' in the top byte, i.e. stream order from MSB down
   localparam logic [31:0] CMD_GET = 32'h67657420;

   localparam logic [1:0] ERR_BADCMD  = 2'd0;
   localparam logic [1:0] ERR_TOOLONG = 2'd1;
   localparam logic [1:0] ERR_BADCHAR = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_KEY,
      ST_LF,
      ST_DROP
   } state_t;

   function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = CMD_GET[31:24];
         2'd1:    b = CMD_GET[23:16];
         2'd2:    b = CMD_GET[15:8];
         default: b = CMD_GET[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mc_key_pack.sv
// Byte-lane key accumulator: writes key bytes by index into a 96-bit work
// register and snapshots it (plus length) to the outputs on emit.
module mc_key_pack
   import mc_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        wr_en,
   input  logic [3:0]  wr_idx,
   input  logic [7:0]  wr_data,
   input  logic        clr,
   input  logic        emit,
   input  logic [7:0]  emit_len,
   output logic [7:0]  key_length,
   output logic [31:0] k0,
   output logic [31:0] k1,
   output logic [31:0] k2
);

   logic [95:0] work;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         work       <= '0;
         key_length <= '0;
         k0         <= '0;
         k1         <= '0;
         k2         <= '0;
      end else begin
         if (emit) begin
            key_length <= emit_len;
            k0         <= work[31:0];
            k1         <= work[63:32];
            k2         <= work[95:64];
         end
         // Clearing after the snapshot leaves the next key zero-padded
         if (emit || clr) begin
            work <= '0;
         end else if (wr_en) begin
            for (int i = 0; i < 12; i++) begin
               if (wr_idx == 4'(i)) work[8*i +: 8] <= wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/mc_key_extract.sv
// Parses framed memcache "get" commands and emits each key as length + k0..k2
// for lookup3. No backpressure: every rx_valid cycle consumes one byte.
module mc_key_extract
   import mc_pkg::*;
#(
   parameter int MAX_KEY = MAX_KEY_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_sop,
   input  logic        rx_eop,
   output logic        key_valid,
   output logic [7:0]  key_length,
   output logic [31:0] k0,
   output logic [31:0] k1,
   output logic [31:0] k2,
   output logic        key_err,
   output logic [1:0]  err_code
);

   localparam logic [3:0] CNT_MAX = 4'(MAX_KEY);

   state_t     state, state_nx, cur;
   logic [3:0] cnt, cnt_nx;
   logic [1:0] idx, idx_nx;
   logic       got_key, got_key_nx;
   logic       wr_en, clr, emit;
   logic       byte_err, abort_old, eop_abort, err_nx;
   logic [1:0] byte_code;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      idx_nx     = idx;
      got_key_nx = got_key;
      cur        = state;
      wr_en      = 1'b0;
      clr        = 1'b0;
      emit       = 1'b0;
      byte_err   = 1'b0;
      byte_code  = ERR_BADCMD;
      abort_old  = 1'b0;
      eop_abort  = 1'b0;
      if (rx_valid) begin
         // A new sop restarts parsing on this byte; the old frame is aborted
         if (rx_sop && state != ST_IDLE) begin
            abort_old = (state != ST_DROP);
            cur       = ST_IDLE;
            state_nx  = ST_IDLE;
         end
         case (cur)
            ST_IDLE: begin
               if (rx_sop) begin
                  if (rx_data == cmd_byte(2'd0)) begin
                     state_nx = ST_CMD;
                     idx_nx   = 2'd1;
                  end else begin
                     byte_err = 1'b1;
                     state_nx = ST_DROP;
                  end
               end
            end
            ST_CMD: begin
               if (rx_data == cmd_byte(idx)) begin
                  if (idx == 2'd3) begin
                     state_nx   = ST_KEY;
                     cnt_nx     = 4'd0;
                     got_key_nx = 1'b0;
                     clr        = 1'b1;
                  end else begin
                     idx_nx = idx + 2'd1;
                  end
               end else begin
                  byte_err = 1'b1;
                  state_nx = ST_DROP;
               end
            end
            ST_KEY: begin
               if (rx_data >= CH_PR_LO && rx_data <= CH_PR_HI) begin
                  if (cnt >= CNT_MAX) begin
                     byte_err  = 1'b1;
                     byte_code = ERR_TOOLONG;
                     state_nx  = ST_DROP;
                  end else begin
                     wr_en  = 1'b1;
                     cnt_nx = cnt + 4'd1;
                  end
               end else if (rx_data == CH_SP) begin
                  if (cnt != 4'd0) begin
                     emit       = 1'b1;
                     cnt_nx     = 4'd0;
                     got_key_nx = 1'b1;
                  end
               end else if (rx_data == CH_CR) begin
                  if (cnt != 4'd0) begin
                     emit       = 1'b1;
                     cnt_nx     = 4'd0;
                     got_key_nx = 1'b1;
                     state_nx   = ST_LF;
                  end else if (!got_key) begin
                     byte_err = 1'b1;
                     state_nx = ST_DROP;
                  end else begin
                     state_nx = ST_LF;
                  end
               end else begin
                  byte_err  = 1'b1;
                  byte_code = ERR_BADCHAR;
                  state_nx  = ST_DROP;
               end
            end
            ST_LF: begin
               if (rx_data == CH_LF) begin
                  state_nx = ST_IDLE;
               end else begin
                  byte_err = 1'b1;
                  state_nx = ST_DROP;
               end
            end
            ST_DROP: ;
            default: state_nx = ST_IDLE;
         endcase
         if (rx_eop) begin
            eop_abort = (state_nx != ST_IDLE) && (state_nx != ST_DROP);
            state_nx  = ST_IDLE;
         end
      end
      err_nx = byte_err | abort_old | eop_abort;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         got_key   <= 1'b0;
         key_valid <= 1'b0;
         key_err   <= 1'b0;
         err_code  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         got_key   <= got_key_nx;
         key_valid <= emit;
         key_err   <= err_nx;
         if (err_nx) err_code <= byte_err ? byte_code : ERR_ABORT;
      end
   end

   mc_key_pack u_pack (
      .CLK        (CLK),
      .RST        (RST),
      .wr_en      (wr_en),
      .wr_idx     (cnt),
      .wr_data    (rx_data),
      .clr        (clr),
      .emit       (emit),
      .emit_len   ({4'd0, cnt}),
      .key_length (key_length),
      .k0         (k0),
      .k1         (k1),
      .k2         (k2)
   );

endmodule

// File: tb/tb_mc_key_extract.sv
// Directed bench for mc_key_extract: framed command strings in, expected keys
// and error codes queued by hand and matched against observed pulses.
module tb_mc_key_extract;

   logic        CLK;
   logic        RST;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic        rx_eop;
   logic        key_valid;
   logic [7:0]  key_length;
   logic [31:0] k0, k1, k2;
   logic        key_err;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_fails  = 0;

   logic [103:0] exp_key_q[$];
   logic [1:0]   exp_err_q[$];

   mc_key_extract dut (
      .CLK        (CLK),
      .RST        (RST),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_sop     (rx_sop),
      .rx_eop     (rx_eop),
      .key_valid  (key_valid),
      .key_length (key_length),
      .k0         (k0),
      .k1         (k1),
      .k2         (k2),
      .key_err    (key_err),
      .err_code   (err_code)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h required %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
      @(negedge CLK);
      rx_data  = d;
      rx_valid = 1'b1;
      rx_sop   = sop;
      rx_eop   = eop;
   endtask

   task automatic idle_cycle();
      @(negedge CLK);
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic send_frame(input string s, input bit sop, input bit eop, input int max_gap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], sop && (i == 0), eop && (i == s.len() - 1));
         if (i != s.len() - 1) repeat ($urandom_range(0, max_gap)) idle_cycle();
      end
   endtask

   task automatic push_key(input logic [7:0] len, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2);
      exp_key_q.push_back({len, e2, e1, e0});
   endtask

   // scoreboard
   always @(negedge CLK) begin
      if (!RST) begin
         if (key_valid) begin
            if (exp_key_q.size() == 0) check("key_unexpected", 104'(key_valid), 104'd0);
            else check("key", {key_length, k2, k1, k0}, exp_key_q.pop_front());
         end
         if (key_err) begin
            if (exp_err_q.size() == 0) check("err_unexpected", 104'(key_err), 104'd0);
            else check("err_code", 104'(err_code), 104'(exp_err_q.pop_front()));
         end
      end
   end

   initial begin
      RST      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_outputs", {key_valid, key_err, err_code, key_length, k0, k1, k2},
            104'd0);
      RST = 1'b0;
      repeat (2) idle_cycle();

      // single key, pulse one cycle after CR
      push_key(8'd4, 32'h64636261, 32'h0, 32'h0);
      send_frame("get abcd\015", 1, 0, 0);
      @(posedge CLK);
      #1 check("key_latency", 104'(key_valid), 104'd1);
      send_frame("\n", 0, 1, 0);
      repeat (3) idle_cycle();

      // multi-get
      push_key(8'd3, 32'h006f6f66, 32'h0, 32'h0);
      push_key(8'd3, 32'h00726162, 32'h0, 32'h0);
      send_frame("get foo bar\015\n", 1, 1, 2);
      repeat (3) idle_cycle();

      // full 12-byte key
      push_key(8'd12, 32'h64636261, 32'h68676665, 32'h6c6b6a69);
      send_frame("get abcdefghijkl\015\n", 1, 1, 1);
      repeat (3) idle_cycle();

      // 13-byte key then a normal frame
      exp_err_q.push_back(2'd1);
      send_frame("get abcdefghijklm\015\n", 1, 1, 1);
      push_key(8'd4, 32'h64636261, 32'h0, 32'h0);
      send_frame("get abcd\015\n", 1, 1, 2);
      repeat (3) idle_cycle();

      exp_err_q.push_back(2'd0);
      send_frame("set x\015\n", 1, 1, 1);
      repeat (3) idle_cycle();

      exp_err_q.push_back(2'd2);
      send_frame("get a\tb\015\n", 1, 1, 1);
      repeat (3) idle_cycle();
      check("err_code_held", 104'(err_code), 104'd2);

      exp_err_q.push_back(2'd3);
      send_frame("get ab", 1, 1, 1);
      repeat (3) idle_cycle();

      exp_err_q.push_back(2'd0);
      send_frame("get \015\n", 1, 1, 0);
      repeat (3) idle_cycle();

      // new sop mid-key: old frame aborted, new one parses
      exp_err_q.push_back(2'd3);
      push_key(8'd1, 32'h0000007a, 32'h0, 32'h0);
      send_frame("get xy", 1, 0, 1);
      send_frame("get z\015\n", 1, 1, 1);
      repeat (3) idle_cycle();

      // eop on CR: key and abort in the same cycle
      push_key(8'd1, 32'h00000071, 32'h0, 32'h0);
      exp_err_q.push_back(2'd3);
      send_frame("get q\015", 1, 1, 0);
      repeat (3) idle_cycle();

      // trailing space before CR
      push_key(8'd1, 32'h00000061, 32'h0, 32'h0);
      send_frame("get a \015\n", 1, 1, 1);
      repeat (3) idle_cycle();

      // bytes without sop in idle are ignored
      send_frame("xyz\015\n", 0, 1, 1);
      repeat (3) idle_cycle();

      // reset mid-key
      send_frame("get ab", 1, 0, 0);
      @(negedge CLK);
      rx_valid = 1'b0;
      #2 RST = 1'b1;
      #1 check("reset_mid_key", {key_valid, key_err, err_code, key_length, k0, k1, k2},
               104'd0);
      @(negedge CLK);
      RST = 1'b0;
      send_frame("cd\015\n", 0, 1, 1);
      repeat (3) idle_cycle();
      push_key(8'd2, 32'h00006b6f, 32'h0, 32'h0);
      send_frame("get ok\015\n", 1, 1, 2);
      repeat (4) idle_cycle();

      check("keys_pending", 104'(exp_key_q.size()), 104'd0);
      check("errs_pending", 104'(exp_err_q.size()), 104'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
